sdram_read_prefetch_fifo: RTL and testbench

Downstream stage of the SDRAM read facade. Issues burst read requests to the facade and captures returned pixels into a show-ahead FIFO. The VGA pixel pipeline drains the FIFO at pixel rate. The block hides SDRAM latency and refresh gaps, and resynchronises to frame start through a flush.

---
 rtl/sdram_read_prefetch_fifo.sv | 152 +++++++++++++++
 tb/tb_sdram_read_prefetch_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_read_prefetch_fifo.sv
// Burst prefetcher and show-ahead pixel FIFO between the SDRAM read facade and the VGA pipeline.
// Build option PREFETCH_STATS_EN adds o_starve_cnt (cycles with nothing to show, outside DRAIN).
module sdram_read_prefetch_fifo #(
    parameter int PixelBitWidth    = 16,
    parameter int BurstLengthSDRAM = 8,
    parameter int FifoDepth        = 64
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             i_flush,
    output logic                             o_read_req,
    input  logic                             i_busy_rd,
    input  logic                             i_ready,
    input  logic [PixelBitWidth-1:0]         i_pixel,
    input  logic                             i_pop,
    output logic [PixelBitWidth-1:0]         o_pixel,
    output logic                             o_valid,
    output logic [$clog2(FifoDepth):0]       o_level,
    output logic                             o_overflow,
    output logic                             o_underrun,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]                      o_starve_cnt,
`endif
    output logic [1:0]                       o_state
);

    localparam int PtrW  = $clog2(FifoDepth);
    localparam int LvlW  = PtrW + 1;
    localparam int OwedW = $clog2(BurstLengthSDRAM) + 1;
    localparam logic [LvlW-1:0]  DepthLvl   = LvlW'(FifoDepth);
    localparam logic [LvlW:0]    ReserveMax = (LvlW+1)'(FifoDepth - BurstLengthSDRAM);
    localparam logic [OwedW-1:0] OwedBurst  = OwedW'(BurstLengthSDRAM);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                   state, state_next;
    logic [OwedW-1:0]         owed, owed_next;
    logic [PtrW-1:0]          wr_ptr, rd_ptr;
    logic [LvlW-1:0]          level;
    logic [PixelBitWidth-1:0] mem [FifoDepth];

    logic [LvlW:0] reserved;
    logic          space_ok, full, pop_ok, pop_empty, push, ovf_evt;

    // Handshakes: i_ready is a one-cycle data strobe with no backpressure; i_pop takes the
    // head only while o_valid=1; o_read_req is a single-cycle pulse answered by exactly one burst.
    assign reserved  = {1'b0, level} + (LvlW+1)'(owed);
    assign space_ok  = reserved <= ReserveMax;
    assign full      = level == DepthLvl;
    assign pop_ok    = i_pop && !i_flush && (level != '0);
    assign pop_empty = i_pop && !i_flush && (level == '0);
    assign push      = i_ready && !i_flush && (state == S_WAIT) && (owed != '0) && (!full || pop_ok);
    assign ovf_evt   = i_ready && !i_flush && full && !pop_ok;

    always_comb begin
        state_next = state;
        owed_next  = owed;
        case (state)
            S_IDLE: begin
                if (!i_flush && !i_busy_rd && space_ok) state_next = S_REQ;
            end
            S_REQ: begin
                // The request is already on the wire, so a flush here still owes a full burst.
                owed_next  = OwedBurst;
                state_next = i_flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT, S_DRAIN: begin
                if (i_flush) begin
                    state_next = (owed != '0) ? S_DRAIN : S_IDLE;
                end else if (owed == '0) begin
                    state_next = S_IDLE;
                end else if (i_ready) begin
                    owed_next = owed - 1'b1;
                    if (owed == OwedW'(1)) state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                owed_next  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= S_IDLE;
            owed       <= '0;
            o_read_req <= 1'b0;
        end else begin
            state      <= state_next;
            owed       <= owed_next;
            o_read_req <= (state_next == S_REQ);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LvlW'(push) - LvlW'(pop_ok);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= i_pixel;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_overflow <= 1'b0;
            o_underrun <= 1'b0;
        end else if (i_flush) begin
            o_overflow <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            if (ovf_evt)   o_overflow <= 1'b1;
            if (pop_empty) o_underrun <= 1'b1;
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            o_starve_cnt <= '0;
        end else if (i_flush) begin
            o_starve_cnt <= '0;
        end else if (!o_valid && state != S_DRAIN && o_starve_cnt != 16'hFFFF) begin
            o_starve_cnt <= o_starve_cnt + 16'd1;
        end
    end
`endif

    // Gating by o_valid keeps the head at zero while empty, including straight out of reset.
    assign o_valid = level != '0;
    assign o_pixel = o_valid ? mem[rd_ptr] : '0;
    assign o_level = level;
    assign o_state = state;

endmodule

// File: tb/tb_sdram_read_prefetch_fifo.sv
// Bench for sdram_read_prefetch_fifo: bench-side facade model plus a pixel queue reference.
module tb_sdram_read_prefetch_fifo;

    localparam int W  = 16;
    localparam int BL = 8;
    localparam int D  = 64;

    logic         CLK;
    logic         RST;
    logic         i_flush, i_busy_rd, i_ready, i_pop;
    logic [W-1:0] i_pixel;
    logic         o_read_req, o_valid, o_overflow, o_underrun;
    logic [W-1:0] o_pixel;
    logic [6:0]   o_level;
    logic [1:0]   o_state;
`ifdef PREFETCH_STATS_EN
    logic [15:0]  o_starve_cnt;
`endif

    sdram_read_prefetch_fifo #(
        .PixelBitWidth(W), .BurstLengthSDRAM(BL), .FifoDepth(D)
    ) dut (
        .CLK(CLK), .RST(RST), .i_flush(i_flush), .o_read_req(o_read_req),
        .i_busy_rd(i_busy_rd), .i_ready(i_ready), .i_pixel(i_pixel), .i_pop(i_pop),
        .o_pixel(o_pixel), .o_valid(o_valid), .o_level(o_level),
        .o_overflow(o_overflow), .o_underrun(o_underrun),
`ifdef PREFETCH_STATS_EN
        .o_starve_cnt(o_starve_cnt),
`endif
        .o_state(o_state)
    );

    // clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // reference model: accepted pixels in arrival order, sticky flags
    logic [W-1:0] exp_q[$];
    logic exp_ovf = 1'b0;
    logic exp_und = 1'b0;

    // facade model
    int           fac_left = 0;
    int           fac_wait = 0;
    int           fac_lat = 3;
    int           fac_gap_pct = 0;
    int           fac_burst = BL;
    bit           fac_live = 1'b0;
    bit           fac_seq = 1'b1;
    logic [W-1:0] seq_val = 16'h0001;

    bit busy_force = 1'b0;
    bit pop_req = 1'b0;
    bit flush_req = 1'b0;
    bit last_busy = 1'b0;
    bit last_flush = 1'b0;
    bit prev_req = 1'b0;
    int req_cnt = 0;
    int pop_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check outputs 1ns after the edge.
    task automatic cycle();
        logic         strobe;
        logic [W-1:0] pix;
        bit           pop_ok;
        int           sz;
        strobe = 1'b0;
        pix    = '0;
        if (fac_left > 0 && !flush_req) begin
            if (fac_wait > 0) begin
                fac_wait--;
            end else if ($urandom_range(0, 99) >= fac_gap_pct) begin
                strobe = 1'b1;
                pix = fac_seq ? seq_val : W'($urandom);
                if (fac_seq) seq_val++;
                fac_left--;
            end
        end
        i_ready   = strobe;
        i_pixel   = pix;
        i_busy_rd = busy_force;
        i_flush   = flush_req;
        i_pop     = pop_req;

        sz = exp_q.size();
        if (!RST || flush_req) begin
            exp_q.delete();
            exp_ovf  = 1'b0;
            exp_und  = 1'b0;
            fac_live = 1'b0;
        end else begin
            pop_ok = pop_req && sz > 0;
            if (pop_req && sz == 0) exp_und = 1'b1;
            if (pop_ok) begin
                check("pop_pixel", 32'(o_pixel), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                pop_cnt++;
            end
            if (strobe) begin
                if (sz == D && !pop_ok) exp_ovf = 1'b1;
                else if (fac_live) exp_q.push_back(pix);
            end
        end
        last_busy  = busy_force;
        last_flush = flush_req;

        @(posedge CLK);
        #1;
        check("level", 32'(o_level), 32'(exp_q.size()));
        check("valid", 32'(o_valid), 32'(exp_q.size() != 0));
        check("overflow", 32'(o_overflow), 32'(exp_ovf));
        check("underrun", 32'(o_underrun), 32'(exp_und));
        if (o_read_req) begin
            req_cnt++;
            check("req_single_cycle", 32'(prev_req), 32'd0);
            check("req_outstanding", 32'(fac_left), 32'd0);
            check("req_gating", 32'({last_busy, last_flush}), 32'd0);
            check("req_space", 32'(exp_q.size() + BL <= D), 32'd1);
            fac_left = fac_burst;
            fac_wait = fac_lat;
            fac_live = 1'b1;
        end
        prev_req = o_read_req;
    endtask

    initial begin
        int n;
        int r0;
        i_flush = 1'b0; i_busy_rd = 1'b0; i_ready = 1'b0; i_pop = 1'b0; i_pixel = '0;
        RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        check("rst_read_req", 32'(o_read_req), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_pixel", 32'(o_pixel), 32'd0);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_underrun", 32'(o_underrun), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);
        cycle();
        cycle();
        RST = 1'b1;

        // startup: one burst of 0x0001..0x0008, latency 3
        n = 0;
        while (req_cnt == 0 && n < 20) begin cycle(); n++; end
        check("startup_req_seen", 32'(req_cnt), 32'd1);
        busy_force = 1'b1;
        n = 0;
        while (fac_left > 0 && n < 40) begin cycle(); n++; end
        cycle();
        cycle();
        check("startup_level", 32'(o_level), 32'd8);
        check("startup_req_cnt", 32'(req_cnt), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check("startup_head", 32'(o_pixel), 32'(i));
            pop_req = 1'b1;
            cycle();
        end
        pop_req = 1'b0;
        cycle();
        check("startup_drained", 32'(o_level), 32'd0);

        // fill: no pops, random data, latency and refresh gaps
        fac_seq = 1'b0;
        fac_lat = $urandom_range(1, 5);
        fac_gap_pct = 20;
        req_cnt = 0;
        busy_force = 1'b0;
        for (int i = 0; i < 400; i++) cycle();
        check("fill_req_cnt", 32'(req_cnt), 32'd8);
        check("fill_level", 32'(o_level), 32'd64);
        check("fill_overflow", 32'(o_overflow), 32'd0);

        // misbehaving facade: 9 unsolicited strobes into the full FIFO
        busy_force = 1'b1;
        fac_left = 9;
        fac_wait = 1;
        fac_live = 1'b0;
        n = 0;
        while (fac_left > 0 && n < 60) begin cycle(); n++; end
        cycle();
        check("ovf_flag", 32'(o_overflow), 32'd1);
        check("ovf_level", 32'(o_level), 32'd64);
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        check("flush_clr_ovf", 32'(o_overflow), 32'd0);
        check("flush_level", 32'(o_level), 32'd0);

        // pop while empty
        pop_req = 1'b1;
        cycle();
        pop_req = 1'b0;
        check("und_flag", 32'(o_underrun), 32'd1);
        check("und_level", 32'(o_level), 32'd0);
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        check("flush_clr_und", 32'(o_underrun), 32'd0);

        // streaming: pop whenever something is there, latency 4, >=200 pixels across wraps
        busy_force = 1'b0;
        fac_lat = 4;
        fac_gap_pct = 10;
        pop_cnt = 0;
        n = 0;
        while (pop_cnt < 200 && n < 3000) begin
            pop_req = exp_q.size() > 0;
            cycle();
            n++;
        end
        pop_req = 1'b0;
        check("stream_popped", 32'(pop_cnt >= 200), 32'd1);
        check("stream_underrun", 32'(o_underrun), 32'd0);

        // flush after 3 of 8 pixels of a burst
        busy_force = 1'b1;
        n = 0;
        while (fac_left > 0 && n < 60) begin cycle(); n++; end
        cycle();
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        busy_force = 1'b0;
        fac_lat = 2;
        fac_gap_pct = 0;
        r0 = req_cnt;
        n = 0;
        while (req_cnt == r0 && n < 20) begin cycle(); n++; end
        check("flushmid_req_seen", 32'(req_cnt), 32'(r0 + 1));
        n = 0;
        while (fac_left != 5 && n < 20) begin cycle(); n++; end
        check("flushmid_owed5", 32'(fac_left), 32'd5);
        flush_req = 1'b1;
        cycle();
        flush_req = 1'b0;
        check("flushmid_valid", 32'(o_valid), 32'd0);
        check("flushmid_level", 32'(o_level), 32'd0);
        r0 = req_cnt;
        n = 0;
        while (fac_left > 0 && n < 40) begin cycle(); n++; end
        check("flushmid_no_early_req", 32'(req_cnt), 32'(r0));
        n = 0;
        while (req_cnt == r0 && n < 10) begin cycle(); n++; end
        check("flushmid_req_after", 32'(req_cnt), 32'(r0 + 1));
        busy_force = 1'b1;
        n = 0;
        while (fac_left > 0 && n < 40) begin cycle(); n++; end
        cycle();
        check("flushmid_refill", 32'(o_level), 32'd8);

        // asynchronous reset in WAIT with 5 pixels owed
        busy_force = 1'b0;
        r0 = req_cnt;
        n = 0;
        while (req_cnt == r0 && n < 20) begin cycle(); n++; end
        check("rstmid_req_seen", 32'(req_cnt), 32'(r0 + 1));
        n = 0;
        while (fac_left != 5 && n < 20) begin cycle(); n++; end
        check("rstmid_owed5", 32'(fac_left), 32'd5);
        #3 RST = 1'b0;
        #1;
        check("rstmid_read_req", 32'(o_read_req), 32'd0);
        check("rstmid_valid", 32'(o_valid), 32'd0);
        check("rstmid_level", 32'(o_level), 32'd0);
        check("rstmid_pixel", 32'(o_pixel), 32'd0);
        check("rstmid_state", 32'(o_state), 32'd0);
        busy_force = 1'b1;
        cycle();
        cycle();
        RST = 1'b1;
        n = 0;
        while (fac_left > 0 && n < 40) begin cycle(); n++; end
        check("rstmid_late_ignored", 32'(o_level), 32'd0);
        busy_force = 1'b0;
        r0 = req_cnt;
        n = 0;
        while (req_cnt == r0 && n < 20) begin cycle(); n++; end
        check("rstmid_new_req", 32'(req_cnt), 32'(r0 + 1));
        busy_force = 1'b1;
        n = 0;
        while (fac_left > 0 && n < 40) begin cycle(); n++; end
        cycle();
        check("rstmid_refill", 32'(o_level), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
